// File: rtl/frame_dump_pkg.sv
// rtl/frame_dump_pkg.sv - shared state type and constants for frame_dump_tx
package frame_dump_pkg;

  typedef enum logic [2:0] {IDLE, HDR, ADDR, LOAD, SEND, DONE} state_t;

  localparam logic [7:0] HDR_SYNC0      = 8'hA5;
  localparam logic [7:0] HDR_SYNC1      = 8'h5A;
  localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_holdoff.sv
// rtl/uart_holdoff.sv - saturating idle counter; ready once the UART has been idle long enough
module uart_holdoff #(
  parameter int BITS = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  output logic ready
);

  logic [BITS-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= '0;
    end else if (!(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign ready = (&cnt) & ~busy;

endmodule

// File: rtl/frame_dump_tx.sv
// rtl/frame_dump_tx.sv - raster-order buffer dump to UART, 4 bytes per word MSB first
// Optional 4-byte header (A5 5A W H) when FRAME_DUMP_HEADER_EN is defined.
module frame_dump_tx
  import frame_dump_pkg::*;
#(
  parameter int WIDTH        = 40,
  parameter int HEIGHT       = 30,
  parameter int HOLDOFF_BITS = 13
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_ni,
  input  logic        start_i,
  output logic [5:0]  read_x,
  output logic [4:0]  read_y,
  input  logic [31:0] read_q,
  output logic        uart_wr_o,
  output logic [7:0]  uart_dat_o,
  input  logic        uart_busy_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [1:0] LAST_Z = 2'(BYTES_PER_WORD - 1);

  state_t      state, state_next;
  logic [5:0]  x, x_next;
  logic [4:0]  y, y_next;
  logic [1:0]  z, z_next;
  logic [31:0] word, word_next;
  logic        wr, wr_next;
  logic [7:0]  dat, dat_next;
  logic        ready;
  logic        issue;

  uart_holdoff #(.BITS(HOLDOFF_BITS)) u_holdoff (
    .clk   (sys_clk_i),
    .rst_n (sys_rst_ni),
    .busy  (uart_busy_i),
    .ready (ready)
  );

  // The strobe is registered, so blocking on it keeps strobes at least a cycle apart.
  assign issue = ready & ~wr;

`ifdef FRAME_DUMP_HEADER_EN
  logic [7:0] hdr_byte;

  always_comb begin
    case (z)
      2'd0:    hdr_byte = HDR_SYNC0;
      2'd1:    hdr_byte = HDR_SYNC1;
      2'd2:    hdr_byte = 8'(WIDTH);
      default: hdr_byte = 8'(HEIGHT);
    endcase
  end
`endif

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      word  <= '0;
      wr    <= 1'b0;
      dat   <= '0;
    end else begin
      state <= state_next;
      x     <= x_next;
      y     <= y_next;
      z     <= z_next;
      word  <= word_next;
      wr    <= wr_next;
      dat   <= dat_next;
    end
  end

  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    z_next     = z;
    word_next  = word;
    wr_next    = 1'b0;
    dat_next   = dat;
    case (state)
      IDLE: begin
        if (start_i) begin
          x_next = '0;
          y_next = '0;
          z_next = '0;
`ifdef FRAME_DUMP_HEADER_EN
          state_next = HDR;
`else
          state_next = ADDR;
`endif
        end
      end
`ifdef FRAME_DUMP_HEADER_EN
      HDR: begin
        if (issue) begin
          wr_next  = 1'b1;
          dat_next = hdr_byte;
          z_next   = z + 2'd1;
          if (z == LAST_Z) state_next = ADDR;
        end
      end
`endif
      ADDR: state_next = LOAD;
      LOAD: begin
        word_next  = read_q;
        z_next     = '0;
        state_next = SEND;
      end
      SEND: begin
        if (issue) begin
          wr_next   = 1'b1;
          dat_next  = word[31:24];
          word_next = {word[23:0], 8'h00};
          z_next    = z + 2'd1;
          if (z == LAST_Z) begin
            if (x < 6'(WIDTH - 1)) begin
              x_next     = x + 6'd1;
              state_next = ADDR;
            end else if (y < 5'(HEIGHT - 1)) begin
              x_next     = '0;
              y_next     = y + 5'd1;
              state_next = ADDR;
            end else begin
              state_next = DONE;
            end
          end
        end
      end
      DONE: begin
        x_next     = '0;
        y_next     = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign read_x     = x;
  assign read_y     = y;
  assign uart_wr_o  = wr;
  assign uart_dat_o = dat;
  assign busy_o     = (state != IDLE);
  assign done_o     = (state == DONE);

endmodule

// File: tb/tb_frame_dump_tx.sv
// tb/tb_frame_dump_tx.sv - self-checking bench for frame_dump_tx (2x2 buffer, 2-bit holdoff)
module tb_frame_dump_tx;

  localparam int          W      = 2;
  localparam int          H      = 2;
  localparam int          HB     = 2;
  localparam logic [31:0] POISON = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  rx;
  logic [4:0]  ry;
  logic [31:0] rq = '0;
  logic        wr;
  logic [7:0]  dat;
  logic        ub;
  logic        bo;
  logic        dn;

  always #5 clk = ~clk;

  frame_dump_tx #(.WIDTH(W), .HEIGHT(H), .HOLDOFF_BITS(HB)) dut (
    .sys_clk_i   (clk),
    .sys_rst_ni  (rst_n),
    .start_i     (start),
    .read_x      (rx),
    .read_y      (ry),
    .read_q      (rq),
    .uart_wr_o   (wr),
    .uart_dat_o  (dat),
    .uart_busy_i (ub),
    .busy_o      (bo),
    .done_o      (dn)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] word_of(input int x, input int y);
    logic [3:0] xn;
    logic [3:0] yn;
    xn = 4'(x);
    yn = 4'(y);
    return {4'h1, yn, xn, 4'h2, yn, xn, 8'h34};
  endfunction

  // UART: busy for busy_cyc cycles after each strobe.
  int busy_cyc = 10;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (wr) busy_cnt <= busy_cyc;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign ub = (busy_cnt != 0);

  // RAM: registered read; in xmode the data is poisoned except one cycle after a new address.
  logic       xmode = 1'b0;
  logic       fresh = 1'b0;
  logic [5:0] prev_x = '0;
  logic [4:0] prev_y = '0;
  logic       prev_bo = 1'b0;
  always @(negedge clk) begin
    fresh   <= (rx != prev_x) || (ry != prev_y) || (bo && !prev_bo);
    prev_x  <= rx;
    prev_y  <= ry;
    prev_bo <= bo;
  end
  always @(posedge clk) rq <= (xmode && !fresh) ? POISON : word_of(int'(rx), int'(ry));

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int done_cnt = 0, viol_busy = 0, viol_b2b = 0, viol_hold = 0, idle = 1000;
  logic prev_wr = 1'b0;

  initial forever begin
    @(negedge clk);
    if (wr) begin
      got_q.push_back(dat);
      if (ub) viol_busy++;
      if (prev_wr) viol_b2b++;
      if (idle < (1 << HB) - 1) viol_hold++;
    end
    if (dn) done_cnt++;
    idle    = ub ? 0 : idle + 1;
    prev_wr = wr;
  end

  function automatic void build_expected();
    logic [31:0] w;
    exp_q.delete();
`ifdef FRAME_DUMP_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(W));
    exp_q.push_back(8'(H));
`endif
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        w = word_of(x, y);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
      end
  endfunction

  task automatic pulse_start(input string tag);
    @(negedge clk);
    check({tag, " busy_before"}, 32'(bo), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_rise"}, 32'(bo), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rst read_x"}, 32'(rx), 32'd0);
    check({tag, " rst read_y"}, 32'(ry), 32'd0);
    check({tag, " rst wr"}, 32'(wr), 32'd0);
    check({tag, " rst dat"}, 32'(dat), 32'd0);
    check({tag, " rst busy"}, 32'(bo), 32'd0);
    check({tag, " rst done"}, 32'(dn), 32'd0);
  endtask

  typedef struct {
    int busy_cyc;
    int restart_at;
    int reset_at;
    int xm;
    int exp_done;
  } vec_t;

  task automatic run_dump(input string tag, input vec_t v);
    int cyc;
    bit restarted;
    bit resetted;
    logic [31:0] act;
    cyc = 0;
    restarted = 1'b0;
    resetted = 1'b0;
    busy_cyc = v.busy_cyc;
    xmode = (v.xm != 0);
`ifdef FRAME_DUMP_HEADER_EN
    xmode = 1'b0;
`endif
    repeat (20) @(negedge clk);
    got_q.delete();
    done_cnt = 0; viol_busy = 0; viol_b2b = 0; viol_hold = 0;
    build_expected();
    pulse_start(tag);
    while (done_cnt == 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (!restarted && v.restart_at >= 0 && got_q.size() >= v.restart_at) begin
        restarted = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
      if (!resetted && v.reset_at >= 0 && got_q.size() >= v.reset_at) begin
        resetted = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        done_cnt = 0;
        repeat (4) @(negedge clk);
        check({tag, " no strobe after release"}, 32'(got_q.size()), 32'd0);
        pulse_start(tag);
      end
    end
    check({tag, " done within budget"}, 32'(done_cnt > 0), 32'd1);
    repeat (40) @(negedge clk);
    check({tag, " byte count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
      check($sformatf("%s byte%0d", tag, i), act, 32'(exp_q[i]));
    end
    check({tag, " done pulses"}, 32'(done_cnt), 32'(v.exp_done));
    check({tag, " busy_o low"}, 32'(bo), 32'd0);
    check({tag, " strobe while busy"}, 32'(viol_busy), 32'd0);
    check({tag, " back-to-back"}, 32'(viol_b2b), 32'd0);
    check({tag, " holdoff"}, 32'(viol_hold), 32'd0);
  endtask

  vec_t vecs[5];
  vec_t rv;

  initial begin
    vecs[0] = '{10, -1, -1, 0, 1};
    vecs[1] = '{ 5, -1, -1, 0, 1};
    vecs[2] = '{ 4,  6, -1, 0, 1};
    vecs[3] = '{ 3, -1,  5, 0, 1};
    vecs[4] = '{ 6, -1, -1, 1, 1};

    #1 check_reset_outputs("init");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_dump($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 4; i++) begin
      rv.busy_cyc   = int'($urandom_range(1, 12));
      rv.restart_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
      rv.reset_at   = -1;
      rv.xm         = int'($urandom_range(0, 1));
      rv.exp_done   = 1;
      run_dump($sformatf("rand%0d", i), rv);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/frame_dump_tx.md
# frame_dump_tx

Downstream consumer of the `downsample` thumbnail buffer. On a start request it walks the buffer in raster order and serialises every 32-bit word as four bytes, MSB first, into the `uart` transmitter. It enforces the inter-byte holdoff and the write/busy handshake. It replaces the ad-hoc sender logic at the top level and runs entirely in the UART clock domain.

## Interface
- `WIDTH`, default 40: words per buffer row; `read_x` counts 0..WIDTH-1.
- `HEIGHT`, default 30: rows per buffer; `read_y` counts 0..HEIGHT-1.
- `HOLDOFF_BITS`, default 13: width of the idle-holdoff counter. A byte may be issued only when the counter is all-ones.

Ports:
- `sys_clk_i`, in, 1: the single clock, 12 MHz.
- `sys_rst_ni`, in, 1: reset, asynchronous and active-low.
- `start_i`, in, 1: single-cycle start request.
- `read_x`, out, 6: buffer column address.
- `read_y`, out, 5: buffer row address.
- `read_q`, in, 32: buffer data, valid 1 cycle after the address changes.
- `uart_wr_o`, out, 1: one-cycle byte write strobe.
- `uart_dat_o`, out, 8: byte to transmit; valid while `uart_wr_o` is high.
- `uart_busy_i`, in, 1: UART transmitting.
- `busy_o`, out, 1: dump in progress.
- `done_o`, out, 1: one-cycle pulse after the last byte is written.

## Operation
- States are `IDLE`, `HDR`, `ADDR`, `LOAD`, `SEND`, `DONE`.
- `IDLE`:
  - On `start_i`: clear x, y and byte index z.
  - Go to `HDR` if the header is compiled in; otherwise go to `ADDR`.
  - `start_i` is ignored in every other state.
- `ADDR`: the address is already driven. Wait one cycle for RAM latency, then go to `LOAD`.
- `LOAD`: latch `read_q` into the 32-bit shift word and set z=0. Go to `SEND`.
- `SEND`:
  - Issue condition: holdoff saturated, `!uart_busy_i`, and `!uart_wr_o`.
  - On issue: assert `uart_wr_o` for one cycle with `uart_dat_o` = word[31:24] and shift the word left 8. Increment z.
  - After the issue with z=3:
    - If x < WIDTH-1: x++, go to `ADDR`.
    - Else if y < HEIGHT-1: x=0, y++, go to `ADDR`.
    - Else go to `DONE`.
- `DONE`: pulse `done_o` for one cycle, clear x and y, go to `IDLE`.
- Holdoff counter:
  - Cleared every cycle `uart_busy_i` is high.
  - Otherwise increments and saturates at all-ones.
  - It runs in all states, so the first byte after an idle period is not delayed.
- `busy_o` is high in every state except `IDLE`.
- Total bytes per dump: WIDTH·HEIGHT·4, plus 4 with the header.

## Timing
- Reset values:
  - `read_x`=0, `read_y`=0, `uart_wr_o`=0, `uart_dat_o`=0, `busy_o`=0, `done_o`=0.
  - Holdoff counter = 0. State = `IDLE`.
- Start to first address: `busy_o` rises the cycle after `start_i` is sampled.
- Address to word latch: `read_x`/`read_y` change on an edge, and `LOAD` samples `read_q` 2 edges later.
- `uart_wr_o` is never high on two consecutive cycles.
- `uart_dat_o` is held until the next issue.
- Minimum byte spacing: busy period + 2^HOLDOFF_BITS − 1 idle cycles.
- `uart_busy_i` rising in the same cycle as an issue does not cancel that issue; the strobe is already registered.
- Reset asserted mid-dump: all outputs return to their reset values immediately. No partial byte strobe is emitted after release.

## Configuration
- `FRAME_DUMP_HEADER_EN` defined:
  - `HDR` emits 4 bytes before the pixels: 0xA5, 0x5A, WIDTH[7:0], HEIGHT[7:0].
  - The header bytes use the same issue rule as pixel bytes.
- `FRAME_DUMP_HEADER_EN` undefined: `HDR` is absent, and the byte stream starts with pixel (0,0) byte 3 (bits 31:24).

## Structure
- `frame_dump_pkg` holds:
  - the state enum;
  - header byte constants 0xA5/0x5A;
  - `BYTES_PER_WORD`=4.
- Sub-module `uart_holdoff`: the saturating counter with clear-on-busy. It outputs `ready` = saturated & !busy.
- Everything else stays flat.

## Test plan
All scenarios use WIDTH=2, HEIGHT=2, HOLDOFF_BITS=2, header off unless stated. The RAM model returns {y,x,y,x} nibble-packed.
- Basic dump: pulse start; UART model busy 10 cycles per byte -> exactly 16 strobes in order (0,0)…(1,1), each word MSB first. `done_o` pulses once. `busy_o` then falls.
- Holdoff: busy model 5 cycles -> each strobe is ≥ 3 idle cycles after busy falls. No strobe occurs while busy is high.
- Start while busy: second `start_i` mid-dump -> ignored. Strobe count stays 16, and a single `done_o` pulse occurs.
- Reset mid-dump: assert `sys_rst_ni`=0 after 5 bytes -> outputs go to 0 asynchronously. A restart yields the full 16 bytes from (0,0).
- Header build: `FRAME_DUMP_HEADER_EN` defined -> first bytes are 0xA5, 0x5A, 0x02, 0x02, then 16 pixel bytes.
- Read latency: RAM model drives X on `read_q` except 1 cycle after an address change -> no X ever appears on `uart_dat_o`.
